mmio_sequencer: RTL and testbench

- Request sequencer between the VM core's load/store stage and the MMIO memory block.
- Accepts one memory request at a time on a valid/ready handshake and decodes the 16-bit VM address into a ROM/RAM select plus an index.
- Drives the MMIO strobes for one cycle and absorbs MMIO's one-cycle registered read latency.
- Returns data or a fault on a response handshake that tolerates back-pressure.

---
 rtl/mmio_sequencer_if.sv | 32 +++
 rtl/mmio_sequencer.sv | 146 ++++++++++++++
 tb/tb_mmio_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_sequencer_if.sv
// Bundle of the core-side request/response handshake and the MMIO strobe bus.
// The sequencer is the slave of the core and drives the MMIO side.
interface mmio_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic        mem_load_en;
    logic        mem_store_en;
    logic        mem_use_ram;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [7:0]  fault_count;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_fault,
        output mem_load_en, mem_store_en, mem_use_ram, mem_addr, mem_wdata, fault_count
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_fault,
        input  mem_load_en, mem_store_en, mem_use_ram, mem_addr, mem_wdata, fault_count
    );
endinterface

// File: rtl/mmio_sequencer.sv
// One-outstanding-request sequencer between the VM load/store stage and MMIO.
// Decodes ROM/RAM select and index, pulses the strobes, absorbs read latency.
module mmio_sequencer #(
    parameter int ROM_DEPTH = 8,
    parameter int RAM_DEPTH = 8
) (
    input logic              clk,
    input logic              rst,
    mmio_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [15:0] ROM_LIM = 16'(ROM_DEPTH);
    localparam logic [15:0] RAM_LIM = 16'(RAM_DEPTH);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic        mem_use_ram_q, mem_use_ram_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_load_en_q, mem_load_en_d;
    logic        mem_store_en_q, mem_store_en_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [7:0]  fault_count_q, fault_count_d;

    logic [15:0] req_idx;
    logic        req_fault;

    // Stores to ROM are rejected along with any out-of-range index.
    always_comb begin
        req_idx   = {1'b0, bus.req_addr[14:0]};
        req_fault = 1'b0;
        if (bus.req_addr[15]) begin
            req_fault = (req_idx >= RAM_LIM);
        end else begin
            req_fault = bus.req_write || (req_idx >= ROM_LIM);
        end
    end

    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        mem_use_ram_d  = mem_use_ram_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_load_en_d  = 1'b0;
        mem_store_en_d = 1'b0;
        rsp_valid_d    = rsp_valid_q;
        rsp_fault_d    = rsp_fault_q;
        rsp_data_d     = rsp_data_q;
        fault_count_d  = fault_count_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d       = bus.req_write;
                    mem_use_ram_d = bus.req_addr[15];
                    mem_addr_d    = req_idx;
                    mem_wdata_d   = bus.req_wdata;
                    rsp_data_d    = 32'd0;
                    rsp_fault_d   = req_fault;
                    if (req_fault) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        if (fault_count_q != 8'hFF) begin
                            fault_count_d = fault_count_q + 8'd1;
                        end
                    end else begin
                        // Strobes are registered so they are high exactly during ISSUE.
                        state_d        = ISSUE;
                        mem_load_en_d  = ~bus.req_write;
                        mem_store_en_d = bus.req_write;
                    end
                end
            end
            ISSUE: begin
                if (write_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rsp_data_d  = bus.mem_rdata;
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_fault_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_fault_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            write_q        <= 1'b0;
            mem_use_ram_q  <= 1'b0;
            mem_addr_q     <= 16'd0;
            mem_wdata_q    <= 32'd0;
            mem_load_en_q  <= 1'b0;
            mem_store_en_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_fault_q    <= 1'b0;
            rsp_data_q     <= 32'd0;
            fault_count_q  <= 8'd0;
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            mem_use_ram_q  <= mem_use_ram_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_load_en_q  <= mem_load_en_d;
            mem_store_en_q <= mem_store_en_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_fault_q    <= rsp_fault_d;
            rsp_data_q     <= rsp_data_d;
            fault_count_q  <= fault_count_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_fault    = rsp_fault_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.mem_load_en  = mem_load_en_q;
    assign bus.mem_store_en = mem_store_en_q;
    assign bus.mem_use_ram  = mem_use_ram_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.fault_count  = fault_count_q;

endmodule

// File: tb/tb_mmio_sequencer.sv
// Randomized transaction-level bench for mmio_sequencer with an MMIO memory
// model and an array-based reference of ROM/RAM contents and fault rules.
module tb_mmio_sequencer;

    localparam int ROM_DEPTH = 8;
    localparam int RAM_DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_sequencer_if bus ();

    mmio_sequencer #(.ROM_DEPTH(ROM_DEPTH), .RAM_DEPTH(RAM_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int fault_n = 0;

    logic [31:0] rom_img [ROM_DEPTH];
    logic [31:0] mmio_ram [RAM_DEPTH];
    logic [31:0] ref_ram [RAM_DEPTH];

    // MMIO block: one-cycle registered read, garbage on the bus otherwise.
    always @(posedge clk) begin
        if (bus.mem_load_en) begin
            bus.mem_rdata <= bus.mem_use_ram ? mmio_ram[bus.mem_addr[2:0]] : rom_img[bus.mem_addr[2:0]];
        end else begin
            bus.mem_rdata <= $urandom;
        end
        if (bus.mem_store_en && bus.mem_use_ram) begin
            mmio_ram[bus.mem_addr[2:0]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int exp_fcnt();
        return (fault_n > 255) ? 255 : fault_n;
    endfunction

    task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wd, input int bp);
        logic        sel;
        int          idx;
        logic        flt;
        int          exp_lat;
        logic [31:0] exp_data;
        int          lat;
        int          wt;
        int          n_ld;
        int          n_st;
        logic [15:0] s_addr;
        logic        s_ram;
        logic [31:0] s_wd;

        sel = addr[15];
        idx = int'(addr[14:0]);
        flt = sel ? (idx >= RAM_DEPTH) : (wr || idx >= ROM_DEPTH);
        exp_lat  = flt ? 1 : (wr ? 2 : 3);
        exp_data = 32'd0;
        if (!flt && !wr) exp_data = sel ? ref_ram[idx] : rom_img[idx];

        wt = 0;
        while (!bus.req_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        if (!bus.req_ready) chk("ready_wait", 32'(bus.req_ready), 32'd1);

        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = $urandom;

        if (flt) fault_n++;
        if (!flt && wr) ref_ram[idx] = wd;

        lat = 1; n_ld = 0; n_st = 0;
        s_addr = 16'hFFFF; s_ram = 1'b1; s_wd = 32'hFFFF_FFFF;
        forever begin
            if (bus.mem_load_en || bus.mem_store_en) begin
                chk("strobe_excl", 32'(bus.mem_load_en & bus.mem_store_en), 32'd0);
                s_addr = bus.mem_addr;
                s_ram  = bus.mem_use_ram;
                s_wd   = bus.mem_wdata;
            end
            n_ld += int'(bus.mem_load_en);
            n_st += int'(bus.mem_store_en);
            if (bus.rsp_valid || lat >= 10) break;
            @(negedge clk);
            lat++;
        end

        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_fault", 32'(bus.rsp_fault), 32'(flt));
        chk("rsp_data", bus.rsp_data, exp_data);
        chk("load_strobes", 32'(n_ld), (flt || wr) ? 32'd0 : 32'd1);
        chk("store_strobes", 32'(n_st), (flt || !wr) ? 32'd0 : 32'd1);
        if (!flt) begin
            chk("strobe_addr", 32'(s_addr), 32'(idx));
            chk("strobe_sel", 32'(s_ram), 32'(sel));
            if (wr) chk("strobe_wdata", s_wd, wd);
        end
        chk("fault_count", 32'(bus.fault_count), 32'(exp_fcnt()));

        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_data", bus.rsp_data, exp_data);
            chk("bp_fault", 32'(bus.rsp_fault), 32'(flt));
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end

        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_fault"}, 32'(bus.rsp_fault), 32'd0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
        chk({tag, "_load_en"}, 32'(bus.mem_load_en), 32'd0);
        chk({tag, "_store_en"}, 32'(bus.mem_store_en), 32'd0);
        chk({tag, "_use_ram"}, 32'(bus.mem_use_ram), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_fault_count"}, 32'(bus.fault_count), 32'd0);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] a;
        logic        w;

        for (int i = 0; i < ROM_DEPTH; i++) rom_img[i] = $urandom;
        rom_img[3] = 32'hDEADBEEF;
        for (int i = 0; i < RAM_DEPTH; i++) begin
            mmio_ram[i] = $urandom;
            ref_ram[i]  = mmio_ram[i];
        end

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        bus.mem_rdata = 32'd0;

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        do_txn(1'b0, 16'h0003, 32'd0, 0);
        do_txn(1'b1, 16'h8005, 32'h12345678, 0);
        do_txn(1'b0, 16'h8005, 32'd0, 0);
        do_txn(1'b1, 16'h0002, 32'hA5A5A5A5, 0);
        do_txn(1'b0, 16'h8008, 32'd0, 0);
        do_txn(1'b0, 16'h0010, 32'd0, 0);
        chk("three_faults", 32'(bus.fault_count), 32'd3);
        do_txn(1'b0, 16'h0003, 32'd0, 5);

        // Reset landing in the WAIT cycle of a RAM load.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h8001;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        fault_n = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midreset_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("midreset_no_strobe", 32'(bus.mem_load_en | bus.mem_store_en), 32'd0);
        end
        do_txn(1'b0, 16'h8001, 32'd0, 0);

        for (int n = 0; n < 200; n++) begin
            w = 1'($urandom);
            a = {1'($urandom), 15'($urandom_range(0, 11))};
            if ($urandom_range(0, 9) == 0) a[14:0] = 15'($urandom);
            do_txn(w, a, $urandom, int'($urandom_range(0, 3)));
        end

        for (int n = 0; n < 260; n++) begin
            do_txn(1'b0, {1'b1, 15'(RAM_DEPTH + $urandom_range(0, 100))}, 32'd0, 0);
        end
        chk("fault_saturate", 32'(bus.fault_count), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
